maxnet_controller: RTL and testbench

- Sequencing FSM for the 4-lane Maxnet winner-take-all datapath.
- Loads initial values, runs inhibition iterations (compute, then register write-back), and stops on one of three conditions:
  - exactly one lane remains nonzero (winner found);
  - all lanes have reached zero;
  - the iteration limit is reached.
- Sits between the top-level start/done interface and the datapath. Its only datapath feedback is the per-lane nonzero mask.

---
 rtl/maxnet_controller.sv | 170 +++++++++++++++++
 tb/tb_maxnet_controller.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxnet_controller.sv
// maxnet_controller
// Sequencing FSM for a 4-lane Maxnet winner-take-all datapath. A run loads the
// initial lane values, then repeats compute / write-back iterations until one
// lane survives, every lane has reached zero, or the iteration limit is hit.
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   start          run request, only sampled in IDLE (not queued)
//   nz_mask[3:0]   per-lane nonzero flags from the datapath, only used in CHECK
//   ld_init        datapath loads initial values
//   calc_en        datapath computes next values (held CALC_CYCLES cycles)
//   reg_wr         datapath registers capture the computed values
//   busy           high in every state except IDLE
//   done           one-cycle pulse when a run terminates
//   winner[1:0]    surviving lane index, meaningful when winner_valid=1
//   winner_valid   run ended with exactly one nonzero lane
//   err_zero       run ended with all lanes zero
//   err_timeout    run ended at the iteration limit without a winner
//   iter_count     write-back iterations completed in the current/last run
module maxnet_controller #(
    parameter int MAX_ITER    = 15,
    parameter int ITER_W      = 4,
    parameter int CALC_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        nz_mask,
    output logic              ld_init,
    output logic              calc_en,
    output logic              reg_wr,
    output logic              busy,
    output logic              done,
    output logic [1:0]        winner,
    output logic              winner_valid,
    output logic              err_zero,
    output logic              err_timeout,
    output logic [ITER_W-1:0] iter_count
);

    localparam int                CNT_W      = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CALC_LAST  = CNT_W'(CALC_CYCLES - 1);
    localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CHECK, S_CALC, S_UPDATE, S_FIN
    } state_t;

    state_t            r_state, w_next;
    logic [CNT_W-1:0]  r_calc_cnt;
    logic [ITER_W-1:0] r_iter;
    logic [1:0]        r_winner;
    logic              r_winner_valid, r_err_zero, r_err_timeout;

    logic       w_onehot;
    logic [1:0] w_win_idx;
    logic       w_ld, w_calc, w_wr, w_busy, w_done;

    // Exact one-hot match; any other pattern (including multi-bit) is not a winner.
    always_comb begin
        w_onehot  = 1'b1;
        w_win_idx = 2'd0;
        case (nz_mask)
            4'b0001: w_win_idx = 2'd0;
            4'b0010: w_win_idx = 2'd1;
            4'b0100: w_win_idx = 2'd2;
            4'b1000: w_win_idx = 2'd3;
            default: w_onehot  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_ld   = 1'b0;
        w_calc = 1'b0;
        w_wr   = 1'b0;
        w_busy = 1'b1;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (start) w_next = S_LOAD;
            end
            S_LOAD: begin
                w_ld   = 1'b1;
                w_next = S_CHECK;
            end
            S_CHECK: begin
                if (w_onehot || nz_mask == 4'b0000 || r_iter == ITER_LIMIT)
                    w_next = S_FIN;
                else
                    w_next = S_CALC;
            end
            S_CALC: begin
                w_calc = 1'b1;
                if (r_calc_cnt == CALC_LAST) w_next = S_UPDATE;
            end
            S_UPDATE: begin
                w_wr   = 1'b1;
                w_next = S_CHECK;
            end
            S_FIN: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_busy = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    // Strobes are masked by rst so a reset arriving mid-run (e.g. in UPDATE)
    // never lets a write-back or load reach the datapath during the reset cycle.
    assign ld_init = w_ld   & ~rst;
    assign calc_en = w_calc & ~rst;
    assign reg_wr  = w_wr   & ~rst;
    assign busy    = w_busy & ~rst;
    assign done    = w_done & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_calc_cnt     <= '0;
            r_iter         <= '0;
            r_winner       <= 2'd0;
            r_winner_valid <= 1'b0;
            r_err_zero     <= 1'b0;
            r_err_timeout  <= 1'b0;
        end else begin
            r_calc_cnt <= '0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_iter         <= '0;
                        r_winner       <= 2'd0;
                        r_winner_valid <= 1'b0;
                        r_err_zero     <= 1'b0;
                        r_err_timeout  <= 1'b0;
                    end
                end
                S_CHECK: begin
                    // Same priority as the exit decision: winner, then all-zero, then limit.
                    if (w_onehot) begin
                        r_winner       <= w_win_idx;
                        r_winner_valid <= 1'b1;
                    end else if (nz_mask == 4'b0000) begin
                        r_err_zero <= 1'b1;
                    end else if (r_iter == ITER_LIMIT) begin
                        r_err_timeout <= 1'b1;
                    end
                end
                S_CALC:   r_calc_cnt <= r_calc_cnt + 1'b1;
                S_UPDATE: r_iter     <= r_iter + 1'b1;
                default: ;
            endcase
        end
    end

    assign winner       = r_winner;
    assign winner_valid = r_winner_valid;
    assign err_zero     = r_err_zero;
    assign err_timeout  = r_err_timeout;
    assign iter_count   = r_iter;

endmodule

// File: tb/tb_maxnet_controller.sv
// Scoreboard bench for maxnet_controller. A behavioural datapath stand-in feeds
// nz_mask from a per-run mask sequence (one entry per CHECK) and random garbage
// in every other cycle. The reference model walks that sequence with the
// termination rules to predict outcome, iteration count and done time.
module tb_maxnet_controller;
    localparam int MI = 4;
    localparam int IW = 4;
    localparam int CC = 3;

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [3:0]    nz_mask = 4'b0;
    logic          ld_init, calc_en, reg_wr, busy, done;
    logic [1:0]    winner;
    logic          winner_valid, err_zero, err_timeout;
    logic [IW-1:0] iter_count;

    maxnet_controller #(.MAX_ITER(MI), .ITER_W(IW), .CALC_CYCLES(CC)) dut (
        .clk(clk), .rst(rst), .start(start), .nz_mask(nz_mask),
        .ld_init(ld_init), .calc_en(calc_en), .reg_wr(reg_wr), .busy(busy), .done(done),
        .winner(winner), .winner_valid(winner_valid), .err_zero(err_zero),
        .err_timeout(err_timeout), .iter_count(iter_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         t_done;
        logic       wv;
        logic [1:0] win;
        logic       ez;
        logic       et;
        int         n;
    } exp_t;

    exp_t       expq[$];
    exp_t       last;
    logic [3:0] cur_seq[8];
    int         cur_len = 1;
    int         cyc = 0;
    int         tests = 0, fails = 0;
    int         runs = 0, done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        tests++;
        if (act != exp_v) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp_v, cyc);
        end
    endtask

    function automatic logic [3:0] mask_at(input int k);
        return cur_seq[(k < cur_len) ? k : cur_len - 1];
    endfunction

    // Reference model: CHECK k sees mask_at(k) after k write-backs.
    // t0 is the cycle index of the edge that accepts start; done is seen in
    // the cycle after edge t0+2+N*(CC+2).
    function automatic exp_t model(input int t0);
        exp_t e;
        logic [3:0] m;
        int k;
        e = '{t_done: 0, wv: 1'b0, win: 2'd0, ez: 1'b0, et: 1'b0, n: 0};
        for (k = 0; k <= MI; k++) begin
            m = mask_at(k);
            if ($countones(m) == 1) begin
                e.wv = 1'b1;
                for (int b = 0; b < 4; b++) if (m[b]) e.win = 2'(b);
                break;
            end
            if (m == 4'b0000) begin e.ez = 1'b1; break; end
            if (k == MI) begin e.et = 1'b1; break; end
        end
        e.n      = k;
        e.t_done = t0 + 2 + k * (CC + 2);
        return e;
    endfunction

    // Datapath stand-in: the cycle after ld_init or reg_wr is CHECK.
    int   cidx = 0;
    logic dp_chk;
    always @(posedge clk) begin
        dp_chk = !rst && (ld_init || reg_wr);
        if (ld_init)     cidx = 0;
        else if (reg_wr) cidx = cidx + 1;
        #1;
        if (dp_chk) nz_mask = mask_at(cidx);
        else        nz_mask = 4'($urandom);
    end

    // Monitor
    int   excl_bad = 0, pulse_bad = 0, streak_bad = 0, hold_bad = 0;
    int   streak = 0, n_wr = 0, n_calc = 0;
    logic prev_done = 1'b0, have_last = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            streak    = 0;
            prev_done = 1'b0;
            have_last = 1'b0;
        end else begin
            if (int'(ld_init) + int'(calc_en) + int'(reg_wr) > 1) excl_bad++;
            if (done && prev_done) pulse_bad++;
            prev_done = done;
            if (calc_en) streak++;
            else begin
                if (streak != 0 && streak != CC) streak_bad++;
                streak = 0;
            end
            if (have_last && !busy) begin
                if (winner_valid != last.wv || err_zero != last.ez || err_timeout != last.et ||
                    int'(iter_count) != last.n || (last.wv && winner != last.win))
                    hold_bad++;
            end
            if (ld_init) begin
                have_last = 1'b0;
                n_wr      = 0;
                n_calc    = 0;
                chk("cleared_at_start", {winner_valid, err_zero, err_timeout, iter_count}, 0);
            end
            if (reg_wr)  n_wr++;
            if (calc_en) n_calc++;
            if (done) begin
                done_cnt++;
                if (expq.size() == 0) begin
                    chk("unexpected_done", done_cnt, 0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("done_time", cyc, e.t_done);
                    chk("winner_valid", winner_valid, e.wv);
                    if (e.wv) chk("winner", winner, e.win);
                    chk("err_zero", err_zero, e.ez);
                    chk("err_timeout", err_timeout, e.et);
                    chk("iter_count", iter_count, e.n);
                    chk("reg_wr_pulses", n_wr, e.n);
                    chk("calc_cycles", n_calc, e.n * CC);
                    chk("busy_at_done", busy, 1);
                    last      = e;
                    have_last = 1'b1;
                end
            end
        end
    end

    task automatic wait_done(input int target);
        int b = 0;
        while (done_cnt < target && b < 400) begin
            @(posedge clk);
            b++;
        end
        if (done_cnt < target) chk("done_wait_expired", done_cnt, target);
    endtask

    task automatic set_seq(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d, input int len);
        cur_seq[0] = a; cur_seq[1] = b; cur_seq[2] = c; cur_seq[3] = d;
        cur_len = len;
    endtask

    task automatic start_run();
        exp_t e;
        @(negedge clk);
        e = model(cyc + 1);
        expq.push_back(e);
        runs++;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        exp_t e1, e2;
        for (int i = 0; i < 8; i++) cur_seq[i] = 4'b0;
        // Reset state
        repeat (3) @(posedge clk);
        #2;
        chk("reset_outputs", {ld_init, calc_en, reg_wr, busy, done, winner, winner_valid,
                              err_zero, err_timeout, iter_count}, 0);
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", {ld_init, calc_en, reg_wr, busy, done, iter_count}, 0);

        // Already one-hot after load
        set_seq(4'b0100, 4'b0, 4'b0, 4'b0, 1);
        start_run(); wait_done(runs);
        // Converging run
        set_seq(4'b1111, 4'b1011, 4'b1001, 4'b1000, 4);
        start_run(); wait_done(runs);
        // All-zero after first write-back
        set_seq(4'b0110, 4'b0000, 4'b0, 4'b0, 2);
        start_run(); wait_done(runs);
        // Timeout with a stray start pulse mid-run
        set_seq(4'b0011, 4'b0, 4'b0, 4'b0, 1);
        start_run();
        repeat (6) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(runs);

        // Reset while in CALC
        set_seq(4'b1111, 4'b0, 4'b0, 4'b0, 1);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;          // LOAD
        @(negedge clk);                        // CHECK
        @(negedge clk);                        // CALC, first cycle
        chk("in_calc_before_reset", calc_en, 1);
        @(posedge clk); #2 rst = 1'b1;         // still CALC, reset cycle
        #1;
        chk("reset_cycle_strobes", {ld_init, reg_wr, busy}, 0);
        @(posedge clk); #2 rst = 1'b0;
        #1;
        chk("after_midrun_reset", {ld_init, calc_en, reg_wr, busy, done, winner, winner_valid,
                                   err_zero, err_timeout, iter_count}, 0);
        @(negedge clk);
        chk("no_strobe_after_reset", {ld_init, reg_wr}, 0);
        set_seq(4'b1010, 4'b0010, 4'b0, 4'b0, 2);
        start_run(); wait_done(runs);

        // Back-to-back with start held high
        set_seq(4'b0000, 4'b0, 4'b0, 4'b0, 1);
        @(negedge clk);
        e1 = model(cyc + 1);
        expq.push_back(e1);
        runs++;
        start = 1'b1;
        wait_done(runs);
        set_seq(4'b1100, 4'b0100, 4'b0, 4'b0, 2);
        e2 = model(e1.t_done + 2);
        expq.push_back(e2);
        runs++;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(runs);

        // Randomized runs
        repeat (25) begin
            cur_len = $urandom_range(1, 7);
            for (int i = 0; i < 8; i++) cur_seq[i] = 4'($urandom);
            start_run();
            wait_done(runs);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("strobe_exclusive", excl_bad, 0);
        chk("done_single_cycle", pulse_bad, 0);
        chk("calc_streak_len", streak_bad, 0);
        chk("results_hold", hold_bad, 0);
        chk("scoreboard_empty", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
